// File: rtl/id_decode_if.sv
// Handshake and decoded-bundle signals between the fetch side, the id_decode
// stage and its consumer.
interface id_decode_if;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_op;
   logic        is_signed;
   logic [31:0] imm;
   logic        use_imm;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic [31:0] pc_q;
   logic        is_branch;
   logic        illegal;

   modport master (
      output flush, in_valid, instr, pc, out_ready,
      input  in_ready, out_valid, alu_op, is_signed, imm, use_imm,
             rs1, rs2, rd, pc_q, is_branch, illegal
   );

   modport slave (
      input  flush, in_valid, instr, pc, out_ready,
      output in_ready, out_valid, alu_op, is_signed, imm, use_imm,
             rs1, rs2, rd, pc_q, is_branch, illegal
   );
endinterface

// File: rtl/id_decode.sv
// RV32 subset instruction decoder with a single registered output stage
// (valid/ready on both sides, flush discards the held bundle).
module id_decode (
   input  logic        clk,
   input  logic        rst_n,
   id_decode_if.slave  bus
);
   typedef enum logic { EMPTY, FULL } state_t;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_MUL = 4'd2,  ALU_AND = 4'd3,
      ALU_OR  = 4'd4,  ALU_XOR = 4'd5,  ALU_SHL = 4'd6,  ALU_SHR = 4'd7,
      ALU_SLT = 4'd8,  ALU_LUI = 4'd9,  ALU_BEQ = 4'd10, ALU_BNE = 4'd11,
      ALU_BGE = 4'd12, ALU_BLT = 4'd13
   } alu_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   state_t state, state_nx;
   logic   accept, take;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       f7_zero;

   alu_t        d_alu;
   logic        d_signed, d_use_imm, d_branch, d_illegal;
   logic [31:0] d_imm;
   logic [4:0]  d_rs1, d_rs2, d_rd;

   alu_t        q_alu;
   logic        q_signed, q_use_imm, q_branch, q_illegal;
   logic [31:0] q_imm, q_pc;
   logic [4:0]  q_rs1, q_rs2, q_rd;

   assign opcode  = bus.instr[6:0];
   assign f3      = bus.instr[14:12];
   assign f7      = bus.instr[31:25];
   assign f7_zero = (f7 == 7'b0000000);

   always_comb begin
      d_alu     = ALU_ADD;
      d_signed  = 1'b0;
      d_imm     = '0;
      d_use_imm = 1'b0;
      d_rs1     = bus.instr[19:15];
      d_rs2     = bus.instr[24:20];
      d_rd      = bus.instr[11:7];
      d_branch  = 1'b0;
      d_illegal = 1'b0;
      case (opcode)
         OPC_OP: begin
            case (f3)
               3'b000: begin
                  if (f7_zero)                 d_alu = ALU_ADD;
                  else if (f7 == 7'b0100000)   d_alu = ALU_SUB;
                  else if (f7 == 7'b0000001)   d_alu = ALU_MUL;
                  else                         d_illegal = 1'b1;
               end
               3'b111: d_alu = ALU_AND;
               3'b110: d_alu = ALU_OR;
               3'b100: d_alu = ALU_XOR;
               3'b001: d_alu = ALU_SHL;
               3'b101: d_alu = ALU_SHR;
               3'b010: begin d_alu = ALU_SLT; d_signed = 1'b1; end
               default: d_alu = ALU_SLT;
            endcase
            // Only funct3=000 has funct7 variants; everything else needs funct7=0.
            if (f3 != 3'b000 && !f7_zero) d_illegal = 1'b1;
         end
         OPC_OP_IMM: begin
            d_use_imm = 1'b1;
            d_imm     = {{20{bus.instr[31]}}, bus.instr[31:20]};
            case (f3)
               3'b000: d_alu = ALU_ADD;
               3'b111: d_alu = ALU_AND;
               3'b110: d_alu = ALU_OR;
               3'b100: d_alu = ALU_XOR;
               3'b001, 3'b101: begin
                  d_alu = (f3 == 3'b001) ? ALU_SHL : ALU_SHR;
                  d_imm = {27'd0, bus.instr[24:20]};
                  if (!f7_zero) d_illegal = 1'b1;
               end
               3'b010: begin d_alu = ALU_SLT; d_signed = 1'b1; end
               default: d_alu = ALU_SLT;
            endcase
         end
         OPC_LUI: begin
            d_alu     = ALU_LUI;
            d_imm     = {bus.instr[31:12], 12'h000};
            d_use_imm = 1'b1;
            d_rs1     = '0;
         end
         OPC_BRANCH: begin
            d_branch = 1'b1;
            d_rd     = '0;
            d_imm    = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                        bus.instr[30:25], bus.instr[11:8], 1'b0};
            case (f3)
               3'b000: d_alu = ALU_BEQ;
               3'b001: d_alu = ALU_BNE;
               3'b100: begin d_alu = ALU_BLT; d_signed = 1'b1; end
               3'b101: begin d_alu = ALU_BGE; d_signed = 1'b1; end
               3'b110: d_alu = ALU_BLT;
               3'b111: d_alu = ALU_BGE;
               default: d_illegal = 1'b1;
            endcase
         end
         default: d_illegal = 1'b1;
      endcase
      if (d_illegal) begin
         d_alu     = ALU_ADD;
         d_signed  = 1'b0;
         d_imm     = '0;
         d_use_imm = 1'b0;
         d_rd      = '0;
         d_branch  = 1'b0;
      end
   end

   assign bus.out_valid = (state == FULL);
   assign bus.in_ready  = !bus.out_valid || bus.out_ready;
   assign accept        = bus.in_valid && bus.in_ready;
   assign take          = bus.out_valid && bus.out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nx;
   end

   // Flush wins over a same-cycle accept; take+accept keeps the stage FULL.
   always_comb begin
      state_nx = state;
      if (bus.flush)  state_nx = EMPTY;
      else if (accept) state_nx = FULL;
      else if (take)   state_nx = EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_alu     <= ALU_ADD;
         q_signed  <= 1'b0;
         q_imm     <= '0;
         q_use_imm <= 1'b0;
         q_rs1     <= '0;
         q_rs2     <= '0;
         q_rd      <= '0;
         q_pc      <= '0;
         q_branch  <= 1'b0;
         q_illegal <= 1'b0;
      end else if (accept && !bus.flush) begin
         q_alu     <= d_alu;
         q_signed  <= d_signed;
         q_imm     <= d_imm;
         q_use_imm <= d_use_imm;
         q_rs1     <= d_rs1;
         q_rs2     <= d_rs2;
         q_rd      <= d_rd;
         q_pc      <= bus.pc;
         q_branch  <= d_branch;
         q_illegal <= d_illegal;
      end
   end

   assign bus.alu_op    = q_alu;
   assign bus.is_signed = q_signed;
   assign bus.imm       = q_imm;
   assign bus.use_imm   = q_use_imm;
   assign bus.rs1       = q_rs1;
   assign bus.rs2       = q_rs2;
   assign bus.rd        = q_rd;
   assign bus.pc_q      = q_pc;
   assign bus.is_branch = q_branch;
   assign bus.illegal   = q_illegal;
endmodule

// File: tb/tb_id_decode.sv
// Directed-vector bench for id_decode: decode table, handshake, flush and reset.
module tb_id_decode;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;

   id_decode_if bus ();

   id_decode dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   task automatic issue(input logic [31:0] i, input logic [31:0] p);
      bus.instr     = i;
      bus.pc        = p;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n         = 1'b0;
      bus.flush     = 1'b0;
      bus.in_valid  = 1'b0;
      bus.instr     = '0;
      bus.pc        = '0;
      bus.out_ready = 1'b0;
      #2;
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready",  bus.in_ready,  1);
      check("rst_alu_op",    bus.alu_op,    0);
      check("rst_imm",       bus.imm,       0);
      check("rst_pc_q",      bus.pc_q,      0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      issue(32'h40B50533, 32'h100);
      check("sub_valid",   bus.out_valid, 1);
      check("sub_alu",     bus.alu_op,    1);
      check("sub_rs1",     bus.rs1,       10);
      check("sub_rs2",     bus.rs2,       11);
      check("sub_rd",      bus.rd,        10);
      check("sub_use_imm", bus.use_imm,   0);
      check("sub_illegal", bus.illegal,   0);
      check("sub_pc",      bus.pc_q,      32'h100);

      issue(32'hFFF00093, 32'h104);
      check("addi_valid", bus.out_valid, 1);
      check("addi_alu",   bus.alu_op,    0);
      check("addi_imm",   bus.imm,       32'hFFFF_FFFF);
      check("addi_useim", bus.use_imm,   1);
      check("addi_rd",    bus.rd,        1);
      check("addi_pc",    bus.pc_q,      32'h104);

      issue(32'h12345537, 32'h108);
      check("lui_alu",   bus.alu_op,  9);
      check("lui_imm",   bus.imm,     32'h1234_5000);
      check("lui_rs1",   bus.rs1,     0);
      check("lui_rd",    bus.rd,      10);
      check("lui_useim", bus.use_imm, 1);

      issue(32'hFE20CEE3, 32'h10C);
      check("blt_alu",    bus.alu_op,    13);
      check("blt_signed", bus.is_signed, 1);
      check("blt_branch", bus.is_branch, 1);
      check("blt_imm",    bus.imm,       32'hFFFF_FFFC);
      check("blt_rd",     bus.rd,        0);
      check("blt_rs1",    bus.rs1,       1);
      check("blt_rs2",    bus.rs2,       2);
      check("blt_useim",  bus.use_imm,   0);

      issue(32'hFE20EEE3, 32'h110);
      check("bltu_alu",    bus.alu_op,    13);
      check("bltu_signed", bus.is_signed, 0);

      issue(32'h00331293, 32'h114);
      check("slli_alu",   bus.alu_op,  6);
      check("slli_imm",   bus.imm,     3);
      check("slli_useim", bus.use_imm, 1);

      issue(32'h40335293, 32'h118);
      check("srai_illegal", bus.illegal, 1);
      check("srai_alu",     bus.alu_op,  0);
      check("srai_useim",   bus.use_imm, 0);
      check("srai_rd",      bus.rd,      0);

      issue(32'h0020A1B3, 32'h11C);
      check("slt_alu",    bus.alu_op,    8);
      check("slt_signed", bus.is_signed, 1);

      issue(32'h023100B3, 32'h120);
      check("mul_alu", bus.alu_op, 2);

      issue(32'hFFFFFFFF, 32'h124);
      check("ill_valid",   bus.out_valid, 1);
      check("ill_illegal", bus.illegal,   1);
      check("ill_alu",     bus.alu_op,    0);
      check("ill_rd",      bus.rd,        0);
      check("ill_branch",  bus.is_branch, 0);

      // Backpressure: hold A for two cycles while B waits.
      issue(32'h00331293, 32'h200);
      bus.out_ready = 1'b0;
      bus.instr     = 32'h40B50533;
      bus.pc        = 32'h204;
      bus.in_valid  = 1'b1;
      #1;
      check("bp_in_ready0", bus.in_ready, 0);
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         check("bp_hold_valid", bus.out_valid, 1);
         check("bp_hold_pc",    bus.pc_q,      32'h200);
         check("bp_hold_alu",   bus.alu_op,    6);
         check("bp_in_ready",   bus.in_ready,  0);
      end
      bus.out_ready = 1'b1;
      #1;
      check("bp_in_ready1", bus.in_ready, 1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("bp_b_valid", bus.out_valid, 1);
      check("bp_b_pc",    bus.pc_q,      32'h204);
      check("bp_b_alu",   bus.alu_op,    1);
      @(posedge clk); #1;
      check("bp_no_dup", bus.out_valid, 0);

      // Flush beats a same-cycle accept, and empties a full stage.
      bus.instr    = 32'hFFF00093;
      bus.pc       = 32'h300;
      bus.in_valid = 1'b1;
      bus.flush    = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      check("flush_accept", bus.out_valid, 0);
      issue(32'h12345537, 32'h304);
      check("flush_full_pre", bus.out_valid, 1);
      bus.out_ready = 1'b0;
      bus.flush     = 1'b1;
      @(posedge clk); #1;
      bus.flush     = 1'b0;
      check("flush_full", bus.out_valid, 0);

      // Asynchronous reset while a bundle is held.
      issue(32'h40B50533, 32'h400);
      check("mr_pre_valid", bus.out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mr_valid",    bus.out_valid, 0);
      check("mr_pc",       bus.pc_q,      0);
      check("mr_rs1",      bus.rs1,       0);
      check("mr_alu",      bus.alu_op,    0);
      check("mr_in_ready", bus.in_ready,  1);
      @(negedge clk) rst_n = 1'b1;
      issue(32'hFFF00093, 32'h500);
      check("post_rst_valid", bus.out_valid, 1);
      check("post_rst_pc",    bus.pc_q,      32'h500);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
